arb_stream_buffer: RTL and testbench

//  Elastic buffer between the rrp_arbiter output and the board-side data FIFO.
//  - Accepts 32-bit words on the arbiter write handshake and stores them in an

---
 rtl/arb_stream_buffer.sv | 61 ++++++
 tb/tb_arb_stream_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/arb_stream_buffer.sv
// arb_stream_buffer: elastic FIFO between the arbiter write port and the downstream data FIFO
module arb_stream_buffer #(
  parameter int DEPTH_LOG2    = 4,
  parameter int ALMOST_MARGIN = 4,
  parameter int LOST_WIDTH    = 8
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST,
  input  logic                  ARB_WRITE_IN,
  input  logic [31:0]           ARB_DATA_IN,
  output logic                  ARB_READY_OUT,
  input  logic                  FIFO_FULL,
  output logic                  OUT_WRITE,
  output logic [31:0]           OUT_DATA,
  output logic                  ALMOST_FULL,
  output logic [DEPTH_LOG2:0]   FILL_COUNT,
  output logic [31:0]           WORD_CNT,
  output logic [LOST_WIDTH-1:0] LOST_CNT,
  input  logic                  CLR_CNT
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW = DEPTH_LOG2 + 1;
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, fill_next;
  logic full, empty, wr_en, rd_en, drop;
  logic [31:0] word_cnt;
  logic [LOST_WIDTH-1:0] lost_cnt;
  always_comb begin
    full = (wr_ptr ^ rd_ptr) == {1'b1, {DEPTH_LOG2{1'b0}}};
    empty = wr_ptr == rd_ptr;
    wr_en = ARB_WRITE_IN & ~full;
    drop = ARB_WRITE_IN & full;
    rd_en = ~empty & ~FIFO_FULL;
    fill_next = wr_ptr + PW'(wr_en) - rd_ptr - PW'(rd_en);
  end
  assign ARB_READY_OUT = ~full;
  assign FILL_COUNT = wr_ptr - rd_ptr;
  assign WORD_CNT = word_cnt;
  assign LOST_CNT = lost_cnt;
  always_ff @(posedge BUS_CLK)
    if (wr_en) mem[wr_ptr[DEPTH_LOG2-1:0]] <= ARB_DATA_IN;
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      OUT_WRITE <= 1'b0;
      OUT_DATA <= '0;
      ALMOST_FULL <= 1'b0;
      word_cnt <= '0;
      lost_cnt <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(wr_en);
      rd_ptr <= rd_ptr + PW'(rd_en);
      OUT_WRITE <= rd_en;
      if (rd_en) OUT_DATA <= mem[rd_ptr[DEPTH_LOG2-1:0]];
      ALMOST_FULL <= fill_next >= PW'(DEPTH - ALMOST_MARGIN);
      word_cnt <= CLR_CNT ? '0 : word_cnt + 32'(rd_en);
      lost_cnt <= CLR_CNT ? '0 : lost_cnt + LOST_WIDTH'(drop & ~&lost_cnt);
    end
  end
endmodule

// File: tb/tb_arb_stream_buffer.sv
// tb_arb_stream_buffer: queue-model checker plus directed scenarios for arb_stream_buffer
module tb_arb_stream_buffer;
  logic BUS_CLK = 1'b0, BUS_RST = 1'b1, ARB_WRITE_IN = 1'b0, FIFO_FULL = 1'b0, CLR_CNT = 1'b0;
  logic [31:0] ARB_DATA_IN = '0;
  logic ARB_READY_OUT, OUT_WRITE, ALMOST_FULL;
  logic [31:0] OUT_DATA, WORD_CNT;
  logic [4:0] FILL_COUNT;
  logic [7:0] LOST_CNT;
  int n_vec = 0, n_err = 0;
  bit chk_on = 0;
  logic [31:0] m_q[$];
  logic m_ow = 0, m_af = 0;
  logic [31:0] m_od = '0, m_wc = '0;
  logic [7:0] m_lc = '0;

  arb_stream_buffer dut (
    .BUS_CLK(BUS_CLK), .BUS_RST(BUS_RST), .ARB_WRITE_IN(ARB_WRITE_IN), .ARB_DATA_IN(ARB_DATA_IN),
    .ARB_READY_OUT(ARB_READY_OUT), .FIFO_FULL(FIFO_FULL), .OUT_WRITE(OUT_WRITE), .OUT_DATA(OUT_DATA),
    .ALMOST_FULL(ALMOST_FULL), .FILL_COUNT(FILL_COUNT), .WORD_CNT(WORD_CNT), .LOST_CNT(LOST_CNT),
    .CLR_CNT(CLR_CNT));

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: 16-entry queue; full/empty judged on occupancy before the edge
  always @(posedge BUS_CLK) begin : model
    bit full, rd, wr, drop;
    if (BUS_RST) begin
      m_q.delete();
      m_ow = 0; m_od = '0; m_wc = '0; m_lc = '0; m_af = 0;
    end else begin
      full = m_q.size() == 16;
      rd = m_q.size() != 0 && !FIFO_FULL;
      wr = ARB_WRITE_IN && !full;
      drop = ARB_WRITE_IN && full;
      m_ow = rd;
      if (rd) m_od = m_q.pop_front();
      if (wr) m_q.push_back(ARB_DATA_IN);
      m_wc = CLR_CNT ? 0 : m_wc + (rd ? 1 : 0);
      m_lc = CLR_CNT ? 0 : (drop && m_lc != 8'hFF) ? m_lc + 1 : m_lc;
      m_af = m_q.size() >= 12;
    end
  end

  always @(negedge BUS_CLK) if (chk_on) begin
    chk("ready", ARB_READY_OUT, m_q.size() != 16);
    chk("fill", FILL_COUNT, 32'(m_q.size()));
    chk("almost_full", ALMOST_FULL, m_af);
    chk("out_write", OUT_WRITE, m_ow);
    if (m_ow) chk("out_data", OUT_DATA, m_od);
    chk("word_cnt", WORD_CNT, m_wc);
    chk("lost_cnt", LOST_CNT, m_lc);
  end

  task automatic step(input logic w, input logic [31:0] d);
    ARB_WRITE_IN = w;
    ARB_DATA_IN = d;
    @(posedge BUS_CLK);
    #2;
  endtask

  initial begin
    step(0, 0);
    chk_on = 1;
    step(0, 0);
    BUS_RST = 0;
    chk("t0 ready", ARB_READY_OUT, 1);
    chk("t0 data", OUT_DATA, 0);
    // single word, two-cycle latency
    step(1, 32'hDEADBEEF);
    chk("t1 fill", FILL_COUNT, 1);
    chk("t1 early", OUT_WRITE, 0);
    step(0, 0);
    chk("t1 out_write", OUT_WRITE, 1);
    chk("t1 out_data", OUT_DATA, 32'hDEADBEEF);
    chk("t1 word_cnt", WORD_CNT, 1);
    step(0, 0);
    chk("t1 pulse end", OUT_WRITE, 0);
    // fill under backpressure, then overflow
    FIFO_FULL = 1;
    for (int i = 0; i < 16; i++) begin
      step(1, 32'h100 + i);
      if (i == 10) chk("t2 af@11", ALMOST_FULL, 0);
      if (i == 11) chk("t2 af@12", ALMOST_FULL, 1);
      if (i == 14) chk("t2 ready@15", ARB_READY_OUT, 1);
    end
    chk("t2 ready@16", ARB_READY_OUT, 0);
    chk("t2 fill", FILL_COUNT, 16);
    for (int i = 0; i < 3; i++) step(1, 32'hBAD0 + i);
    chk("t2 lost", LOST_CNT, 3);
    // drain in order
    FIFO_FULL = 0;
    step(0, 0);
    chk("t3 first", OUT_DATA, 32'h100);
    for (int i = 1; i < 16; i++) step(0, 0);
    chk("t3 last", OUT_DATA, 32'h10F);
    chk("t3 fill", FILL_COUNT, 0);
    chk("t3 ready", ARB_READY_OUT, 1);
    chk("t3 word_cnt", WORD_CNT, 17);
    step(0, 0);
    // full buffer with write held high: first write dropped, then 1 in/1 out
    FIFO_FULL = 1;
    for (int i = 0; i < 16; i++) step(1, 32'h200 + i);
    FIFO_FULL = 0;
    step(1, 32'h300);
    chk("t4 lost", LOST_CNT, 4);
    chk("t4 fill", FILL_COUNT, 15);
    for (int i = 1; i < 20; i++) step(1, 32'h300 + i);
    chk("t4 steady fill", FILL_COUNT, 15);
    chk("t4 steady write", OUT_WRITE, 1);
    for (int i = 0; i < 17; i++) step(0, 0);
    chk("t4 drained", FILL_COUNT, 0);
    // word counter wrap
    force dut.word_cnt = 32'hFFFF_FFFF;
    m_wc = 32'hFFFF_FFFF;
    step(1, 32'h0C0FFEE0);
    release dut.word_cnt;
    step(0, 0);
    chk("t5 wrap", WORD_CNT, 0);
    chk("t5 data", OUT_DATA, 32'h0C0FFEE0);
    // lost counter saturation and clear priority
    FIFO_FULL = 1;
    for (int i = 0; i < 316; i++) step(1, i);
    chk("t5 lost sat", LOST_CNT, 255);
    CLR_CNT = 1;
    step(1, 32'h55);
    CLR_CNT = 0;
    chk("t5 clr lost", LOST_CNT, 0);
    chk("t5 clr fill", FILL_COUNT, 16);
    step(1, 32'h56);
    chk("t5 lost after clr", LOST_CNT, 1);
    // reset with words buffered
    BUS_RST = 1;
    step(0, 0);
    BUS_RST = 0;
    for (int i = 0; i < 5; i++) step(1, 32'h400 + i);
    chk("t6 fill5", FILL_COUNT, 5);
    FIFO_FULL = 0;
    BUS_RST = 1;
    step(0, 0);
    BUS_RST = 0;
    chk("t6 fill", FILL_COUNT, 0);
    chk("t6 out_write", OUT_WRITE, 0);
    chk("t6 word_cnt", WORD_CNT, 0);
    chk("t6 lost_cnt", LOST_CNT, 0);
    chk("t6 ready", ARB_READY_OUT, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("t6 quiet", OUT_WRITE, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
